i2c_bus_arbiter: RTL and testbench

- Shares the single I2C master (24-bit {slave, sub-address, data} transaction port with START/END/ACK handshake) between NREQ requesters.
- Typical requesters: the HDMI transmitter init sequencer, a runtime reconfig sequencer (DVI/HDMI mode, 48k/96k audio switch) and a debug register port.
- Round-robin arbitration, automatic retry on NACK, per-transaction timeout, per-requester completion and error reporting.

---
 rtl/i2c_bus_arbiter_if.sv | 26 ++
 rtl/i2c_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between the I2C bus arbiter, its requesters and the shared I2C master.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface i2c_bus_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]    REQ;
  logic [24*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]    GNT;
  logic [NREQ-1:0]    DONE;
  logic [NREQ-1:0]    ERR;
  logic               BUSY;
  logic [23:0]        I2C_DATA;
  logic               I2C_START;
  logic               I2C_END;
  logic               I2C_ACK;

  modport slave (
    input  REQ, REQ_DATA, I2C_END, I2C_ACK,
    output GNT, DONE, ERR, BUSY, I2C_DATA, I2C_START
  );

  modport master (
    output REQ, REQ_DATA, I2C_END, I2C_ACK,
    input  GNT, DONE, ERR, BUSY, I2C_DATA, I2C_START
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters, with
// NACK retry, per-attempt timeout and per-requester DONE/ERR pulses.
module i2c_bus_arbiter #(
  parameter int NREQ      = 3,
  parameter int MAX_RETRY = 2,
  parameter int TIMEOUT   = 2_000_000
) (
  input  logic             iCLK,
  input  logic             iRST,
  i2c_bus_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_CHECK, S_FINISH, S_COOLDOWN, S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [23:0]     data_q, data_d;
  logic            start_q, start_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic            found, found_hi;
  logic [IW-1:0]   win, win_hi, win_any, next_rr;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    found    = 1'b0;
    found_hi = 1'b0;
    win_hi   = '0;
    win_any  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.REQ[k]) begin
        found   = 1'b1;
        win_any = IW'(k);
        if (IW'(k) >= rr_q) begin
          found_hi = 1'b1;
          win_hi   = IW'(k);
        end
      end
    end
    win = found_hi ? win_hi : win_any;
  end

  assign next_rr = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    data_d  = data_q;
    start_d = start_q;
    rr_d    = rr_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        // Never start while the master still reports a transfer in flight (e.g. after reset).
        if (!bus.I2C_END) begin
          state_d = S_DRAIN;
        end else if (found) begin
          state_d = S_LAUNCH;
          idx_d   = win;
          gnt_d   = NREQ'(1) << win;
          data_d  = bus.REQ_DATA[24*int'(win) +: 24];
          start_d = 1'b1;
          tmo_d   = '0;
        end
      end
      S_LAUNCH, S_RUN: begin
        tmo_d = tmo_q + 1'b1;
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = gnt_q;
          state_d = S_DRAIN;
        end else if (state_q == S_LAUNCH) begin
          if (!bus.I2C_END) begin
            start_d = 1'b0;
            state_d = S_RUN;
          end
        end else if (bus.I2C_END) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bus.I2C_ACK) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          rr_d    = next_rr;
          state_d = S_FINISH;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = S_LAUNCH;
        end else begin
          err_d   = gnt_q;
          gnt_d   = '0;
          rr_d    = next_rr;
          state_d = S_FINISH;
        end
      end
      S_DRAIN: begin
        // A post-reset drain owns no grant, so the pointer is left alone then.
        if (bus.I2C_END) begin
          if (|gnt_q) rr_d = next_rr;
          gnt_d   = '0;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        retry_d = '0;
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      rr_q    <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
      start_q <= start_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.I2C_DATA  = data_q;
  assign bus.I2C_START = start_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter: a transaction-level model predicts winner,
// outcome, attempt count and timing; a behavioural I2C master answers START requests.
module tb_i2c_bus_arbiter;
  localparam int NREQ      = 3;
  localparam int MAX_RETRY = 2;
  localparam int TIMEOUT   = 200;
  localparam int BOUND     = (MAX_RETRY + 1) * (TIMEOUT + 150);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  i2c_bus_arbiter #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Master model configuration, written by the main process only.
  int m_id    = 0;
  int m_nack  = 0;
  int m_lat   = 2;
  bit m_stall = 1'b0;

  initial begin : master_model
    int seen;
    int given;
    seen = -1;
    given = 0;
    bus.I2C_END = 1'b1;
    bus.I2C_ACK = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.I2C_START && bus.I2C_END && !m_stall) begin
        if (seen != m_id) begin
          seen  = m_id;
          given = 0;
        end
        bus.I2C_END = 1'b0;
        repeat (m_lat) @(posedge clk);
        #1;
        bus.I2C_ACK = (given < m_nack);
        given++;
        bus.I2C_END = 1'b1;
      end
    end
  end

  int          nstart = 0;
  logic [23:0] sdata[$];

  initial begin : start_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.I2C_START && !prev) begin
        nstart++;
        sdata.push_back(bus.I2C_DATA);
      end
      prev = bus.I2C_START;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // Reference model state
  logic [NREQ-1:0] pend;
  logic [23:0]     rdata[NREQ];
  int              mptr;

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) bus.REQ_DATA[24*i +: 24] = rdata[i];
    bus.REQ = pend;
  endtask

  task automatic run_txn(input logic [NREQ-1:0] add, input int nack, input int lat,
                         input bit stall, input bit hold, input logic [NREQ-1:0] late,
                         input bit use_d0, input logic [23:0] d0);
    int w, n, k, b0, base, exp_att, bad;
    bit exp_done;
    logic [23:0] exp_d;
    logic [NREQ-1:0] nl;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      if (add[i] && !pend[i]) rdata[i] = (use_d0 && i == 0) ? d0 : 24'($urandom);
    pend = pend | add;
    drive_reqs();
    w = -1;
    for (int i = 0; i < NREQ; i++)
      if (w < 0 && pend[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
    m_id++;
    m_nack  = nack;
    m_lat   = lat;
    m_stall = stall;
    b0      = nstart;
    base    = sdata.size();
    exp_d   = rdata[w];
    @(posedge clk);
    #1;
    chk("gnt", 32'(bus.GNT), 32'(1 << w));
    chk("i2c_data", 32'(bus.I2C_DATA), 32'(exp_d));
    chk("start", 32'(bus.I2C_START), 32'd1);
    chk("busy", 32'(bus.BUSY), 32'd1);
    @(negedge clk);
    rdata[w] = 24'($urandom);
    drive_reqs();
    n = 0;
    while (!(|bus.DONE || |bus.ERR) && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_done = !stall && (nack <= MAX_RETRY);
    chk("pulse_seen", 32'(|bus.DONE || |bus.ERR), 32'd1);
    chk("done", 32'(bus.DONE), exp_done ? 32'(1 << w) : 32'd0);
    chk("err", 32'(bus.ERR), exp_done ? 32'd0 : 32'(1 << w));
    chk("start_low", 32'(bus.I2C_START), 32'd0);
    if (stall) chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
    else       chk("gnt_clear", 32'(bus.GNT), 32'd0);
    exp_att = stall ? 1 : ((nack < MAX_RETRY) ? nack + 1 : MAX_RETRY + 1);
    chk("attempts", 32'(nstart - b0), 32'(exp_att));
    bad = 0;
    for (int i = base; i < sdata.size(); i++) if (sdata[i] !== exp_d) bad++;
    chk("retry_data", 32'(bad), 32'd0);
    @(negedge clk);
    if (!hold) pend[w] = 1'b0;
    nl = late & ~pend;
    nl[w] = 1'b0;
    for (int i = 0; i < NREQ; i++) if (nl[i]) rdata[i] = 24'($urandom);
    pend = pend | nl;
    drive_reqs();
    @(posedge clk);
    #1;
    chk("pulse_1cyc", 32'({bus.DONE, bus.ERR}), 32'd0);
    @(negedge clk);
    if (hold) begin
      pend[w] = 1'b0;
      drive_reqs();
    end
    k = 1;
    while (bus.BUSY && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_lat", 32'(k), stall ? 32'd3 : 32'd2);
    mptr = (w + 1) % NREQ;
  endtask

  initial begin : main
    int n;
    logic [NREQ-1:0] add, late;
    pend = '0;
    mptr = 0;
    for (int i = 0; i < NREQ; i++) rdata[i] = '0;
    bus.REQ      = '0;
    bus.REQ_DATA = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.GNT), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_start", 32'(bus.I2C_START), 32'd0);
    chk("rst_data", 32'(bus.I2C_DATA), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin with every requester re-raising: order 0,1,2,0,1,2
    for (int t = 0; t < 6; t++) run_txn('1, 0, 4, 1'b0, 1'b0, '0, 1'b0, 24'h0);
    run_txn(3'b001, 0, 100, 1'b0, 1'b0, '0, 1'b1, 24'h980F08);
    run_txn(3'b010, 2, 10, 1'b0, 1'b0, '0, 1'b0, 24'h0);
    run_txn(3'b100, 3, 10, 1'b0, 1'b0, '0, 1'b0, 24'h0);
    run_txn(3'b001, 0, 10, 1'b1, 1'b0, '0, 1'b0, 24'h0);
    // REQ1 rises with DONE[0]; REQ0 overstays by one cycle and must not win again
    run_txn(3'b001, 0, 8, 1'b0, 1'b1, 3'b010, 1'b0, 24'h0);
    run_txn(3'b000, 0, 8, 1'b0, 1'b0, '0, 1'b0, 24'h0);

    for (int t = 0; t < 40; t++) begin
      add = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ((pend | add) == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
      late = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      run_txn(add, $urandom_range(0, 3), $urandom_range(2, 40), $urandom_range(0, 7) == 0,
              1'($urandom_range(0, 1)), late, 1'b0, 24'h0);
    end

    // Reset while the master is mid-transfer
    while (pend != '0) run_txn('0, 0, 4, 1'b0, 1'b0, '0, 1'b0, 24'h0);
    @(negedge clk);
    pend = 3'b001;
    rdata[0] = 24'($urandom);
    drive_reqs();
    m_id++;
    m_nack = 0;
    m_lat = 60;
    m_stall = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_gnt", 32'(bus.GNT), 32'd1);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.GNT), 32'd0);
    chk("arst_start", 32'(bus.I2C_START), 32'd0);
    chk("arst_busy", 32'(bus.BUSY), 32'd0);
    @(negedge clk);
    pend = 3'b010;
    rdata[1] = 24'($urandom);
    drive_reqs();
    m_id++;
    rst = 1'b0;
    mptr = 0;
    @(posedge clk);
    #1;
    chk("drain_busy", 32'(bus.BUSY), 32'd1);
    chk("drain_gnt", 32'(bus.GNT), 32'd0);
    n = 0;
    while (bus.GNT == '0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_len", 32'(n), 32'd53);
    chk("post_rst_gnt", 32'(bus.GNT), 32'b010);
    chk("post_rst_data", 32'(bus.I2C_DATA), 32'(rdata[1]));
    n = 0;
    while (!(|bus.DONE || |bus.ERR) && n < BOUND) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("post_rst_done", 32'(bus.DONE), 32'b010);
    @(negedge clk);
    pend = '0;
    drive_reqs();
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", 32'(bus.BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
